lif_membrane_update: RTL and testbench
======================================

Name: lif_membrane_update

Overview:
- Membrane-state controller for the LIF neuron, sitting around the 9-bit approximate log multiplier.
- Upstream of the multiplier: it drives the operands, mul_a = membrane potential and mul_b = leak factor.
- Downstream of the multiplier: it consumes the 18-bit product one clock later, adds the input current, and saturates the result.
- It compares the result against a threshold, emits a spike, resets the potential and enforces a refractory period.

Parameters:
- V_THRESH, 200, firing threshold (9-bit unsigned); a spike fires when the updated potential is >= V_THRESH.
- REFRAC_CYCLES, 4, number of cycles in_ready stays low after a spike; 0 means no refractory state.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input current valid.
- in_ready  out  1  block can accept a current sample.
- in_current  in  9  unsigned input current for this timestep.
- beta  in  9  leak factor, unsigned Q1.8 (256 = 1.0); sampled at handshake.
- mul_a  out  9  multiplier operand a (registered).
- mul_b  out  9  multiplier operand b (registered).
- mul_p  in  18  multiplier product; valid one clock after mul_a/mul_b change.
- v_mem  out  9  membrane potential (registered).
- spike  out  1  one-cycle spike pulse.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE; v_mem=0, spike=0, mul_a=0, mul_b=0, refractory counter=0, captured current=0.
  - in_ready=1 and busy=0 once rst_n is high.
- States: IDLE, MUL, UPD, REFRAC.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready (cycle 0): capture in_current, mul_a<=v_mem, mul_b<=beta, go to MUL.
- MUL (cycle 1):
  - Operands are stable; the multiplier registers its internal stage on this edge.
  - in_ready=0. Go to UPD.
- UPD (cycle 2): mul_p is valid; compute:
  - decay = mul_p[17] ? 511 : mul_p[16:8].
  - sum10 = decay + captured current (10-bit); vnext = sum10 > 511 ? 511 : sum10.
  - If vnext >= V_THRESH: v_mem<=0 and spike<=1; go to REFRAC with counter=REFRAC_CYCLES, or to IDLE if REFRAC_CYCLES=0.
  - Otherwise: v_mem<=vnext, spike<=0, go to IDLE.
- Latency: v_mem and spike are updated and visible in cycle 3, i.e. 3 clocks after the handshake edge.
- spike: high for exactly one cycle (cycle 3), then 0.
- REFRAC:
  - in_ready=0; v_mem holds its post-spike value.
  - Counter decrements once per cycle; at counter==1 go to IDLE.
  - in_ready therefore returns exactly REFRAC_CYCLES cycles after spike asserts.
- No back-to-back acceptance: maximum throughput is one sample per 3 cycles without a spike.
- mul_a and mul_b hold their last value outside the handshake edge.
- in_valid held high while in_ready=0 is not consumed; the sample is accepted on the first IDLE cycle.
- Reset mid-operation (MUL, UPD or REFRAC):
  - Immediate return to the reset values; the pending product is discarded.
  - The multiplier pipeline has no reset and its stale contents are ignored.
- beta=0 or v_mem=0 gives a multiplier zero output, so decay=0 and vnext=in_current.
- Counter width: $clog2(REFRAC_CYCLES+1), minimum 1 bit.

Optional Feature:
- Macro: LIF_SUBTRACT_RESET_EN.
- Defined: on a spike, v_mem<=vnext-V_THRESH (reset by subtraction; residual charge kept). Refractory behaviour is unchanged.
- Undefined: on a spike, v_mem<=0 (reset to zero).

Test Plan:
- Basic update: after reset, in_current=100, beta=256 → cycle 3: v_mem=100, spike=0; in_ready=1 in cycle 3.
- Spike and refractory: v_mem=100, beta=256 (exact power-of-two product 25600, decay=100), in_current=128 → vnext=228 → spike=1 for one cycle, v_mem=0; in_ready=0 for 4 cycles after the spike. With LIF_SUBTRACT_RESET_EN defined: v_mem=28.
- Leak by half: v_mem=128, beta=128, in_current=0 → v_mem=64, spike=0. Check beta=0 → v_mem=in_current.
- Saturation with V_THRESH=511:
  - in_current=300 → v_mem=300, no spike.
  - Then beta=256, in_current=300 → sum10=600 saturates to 511, spike=1.
- Reset mid-op: pull rst_n low during UPD → v_mem=0, spike=0, busy=0 asynchronously. After release, a new sample in_current=50 gives v_mem=50.
- Held valid: in_valid held high continuously with in_current=250 → the first sample spikes; the next acceptance occurs only after 4 refractory cycles. Check the handshake count equals the number of in_ready&&in_valid edges.

Source files
------------

// File: rtl/lif_membrane_update.sv
// lif_membrane_update
// Membrane-state controller wrapped around an external 9-bit approximate
// log multiplier. A sample is accepted in IDLE, the leak product v_mem*beta
// comes back one clock after the operands are registered, and the decayed
// potential plus input current is saturated to 9 bits, thresholded, and
// either stored or turned into a spike followed by a refractory period.
//
// Optional build macro: LIF_SUBTRACT_RESET_EN
//   defined   -> on a spike the potential keeps its residual (vnext - V_THRESH)
//   undefined -> on a spike the potential is cleared to zero
module lif_membrane_update #(
    parameter int V_THRESH      = 200,
    parameter int REFRAC_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [8:0]  in_current,
    input  logic [8:0]  beta,
    output logic [8:0]  mul_a,
    output logic [8:0]  mul_b,
    input  logic [17:0] mul_p,
    output logic [8:0]  v_mem,
    output logic        spike,
    output logic        busy
);

    // A zero-length refractory period still needs a 1-bit counter to exist.
    localparam int CNT_W = (REFRAC_CYCLES > 0) ? $clog2(REFRAC_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LP_REFRAC = CNT_W'(REFRAC_CYCLES);
    localparam logic [9:0]       LP_THRESH = 10'(V_THRESH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MUL    = 2'd1,
        S_UPD    = 2'd2,
        S_REFRAC = 2'd3
    } state_t;

    state_t           r_state;
    logic [8:0]       r_v_mem;
    logic             r_spike;
    logic [8:0]       r_mul_a;
    logic [8:0]       r_mul_b;
    logic [8:0]       r_current;
    logic [CNT_W-1:0] r_cnt;

    logic [8:0]       w_decay;
    logic [9:0]       w_sum10;
    logic [8:0]       w_vnext;
    logic             w_fire;

    // Decay path: product bit 17 means the Q1.8-scaled result overflows 9 bits,
    // so clamp; then add the captured current and saturate the 10-bit sum.
    always_comb begin
        w_decay = mul_p[17] ? 9'd511 : mul_p[16:8];
        w_sum10 = {1'b0, w_decay} + {1'b0, r_current};
        w_vnext = w_sum10[9] ? 9'd511 : w_sum10[8:0];
        w_fire  = ({1'b0, w_vnext} >= LP_THRESH);
    end

    // Controller: accept, wait for the multiplier, update/fire, refractory hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_v_mem   <= '0;
            r_spike   <= 1'b0;
            r_mul_a   <= '0;
            r_mul_b   <= '0;
            r_current <= '0;
            r_cnt     <= '0;
        end else begin
            r_spike <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_current <= in_current;
                        r_mul_a   <= r_v_mem;
                        r_mul_b   <= beta;
                        r_state   <= S_MUL;
                    end
                end
                S_MUL: begin
                    // Operands are stable; the multiplier captures them on this edge.
                    r_state <= S_UPD;
                end
                S_UPD: begin
                    if (w_fire) begin
`ifdef LIF_SUBTRACT_RESET_EN
                        r_v_mem <= w_vnext - LP_THRESH[8:0];
`else
                        r_v_mem <= '0;
`endif
                        r_spike <= 1'b1;
                        if (REFRAC_CYCLES == 0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt   <= LP_REFRAC;
                            r_state <= S_REFRAC;
                        end
                    end else begin
                        r_v_mem <= w_vnext;
                        r_state <= S_IDLE;
                    end
                end
                S_REFRAC: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_IDLE;
                    end
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready = (r_state == S_IDLE);
    assign busy     = (r_state != S_IDLE);
    assign mul_a    = r_mul_a;
    assign mul_b    = r_mul_b;
    assign v_mem    = r_v_mem;
    assign spike    = r_spike;

endmodule

// File: tb/tb_lif_membrane_update.sv
// Testbench for lif_membrane_update: two instances (default threshold with
// refractory, and threshold 511 without refractory), each with an exact
// one-clock multiplier stand-in, checked against an arithmetic neuron model.
module tb_lif_membrane_update;

`ifdef LIF_SUBTRACT_RESET_EN
    localparam bit SUB_MODE = 1'b1;
`else
    localparam bit SUB_MODE = 1'b0;
`endif
    localparam int TH_M = 200;
    localparam int RC_M = 4;
    localparam int TH_S = 511;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_m = 1'b0;
    logic        valid_s = 1'b0;
    logic [8:0]  cur = '0;
    logic [8:0]  beta = '0;
    logic        rdy_m, busy_m, spike_m, rdy_s, busy_s, spike_s;
    logic [8:0]  a_m, b_m, v_m, a_s, b_s, v_s;
    logic [17:0] p_m, p_s;

    int n_cmp = 0;
    int n_err = 0;
    int mv_m = 0;   // model potential, main instance
    int mv_s = 0;   // model potential, saturation instance

    always #5 clk = ~clk;

    // Multiplier stand-ins: product registered one clock after the operands.
    always @(posedge clk) begin
        p_m <= {9'b0, a_m} * {9'b0, b_m};
        p_s <= {9'b0, a_s} * {9'b0, b_s};
    end

    lif_membrane_update #(.V_THRESH(TH_M), .REFRAC_CYCLES(RC_M)) u_main (
        .clk(clk), .rst_n(rst_n), .in_valid(valid_m), .in_ready(rdy_m),
        .in_current(cur), .beta(beta), .mul_a(a_m), .mul_b(b_m), .mul_p(p_m),
        .v_mem(v_m), .spike(spike_m), .busy(busy_m)
    );

    lif_membrane_update #(.V_THRESH(TH_S), .REFRAC_CYCLES(0)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(valid_s), .in_ready(rdy_s),
        .in_current(cur), .beta(beta), .mul_a(a_s), .mul_b(b_s), .mul_p(p_s),
        .v_mem(v_s), .spike(spike_s), .busy(busy_s)
    );

    // Neuron timestep from plain arithmetic: leak, integrate, clamp, fire.
    function automatic void lif_model(input int v, input int c, input int b, input int th,
                                      output int v_new, output bit fire);
        int prod, decay, vn;
        prod  = v * b;
        decay = (prod >= 131072) ? 511 : prod / 256;
        vn    = decay + c;
        if (vn > 511) vn = 511;
        fire  = (vn >= th);
        if (fire) v_new = SUB_MODE ? (vn - th) : 0;
        else      v_new = vn;
    endfunction

    // Wait (bounded) for in_ready, present one sample for one edge.
    // Returns at the falling edge inside cycle 1 (MUL).
    task automatic start_txn(input bit sel, input logic [8:0] c, input logic [8:0] b,
                             output bit ok);
        int n = 0;
        @(negedge clk);
        while (((sel ? rdy_s : rdy_m) !== 1'b1) && n < 30) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 30);
        cur  = c;
        beta = b;
        if (sel) valid_s = 1'b1;
        else     valid_m = 1'b1;
        $display("txn dut=%0s cur=%0d beta=%0d", sel ? "sat" : "main", c, b);
        @(negedge clk);
        valid_m = 1'b0;
        valid_s = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (v_m !== 9'd0)  begin n_err++; $display("FAIL rst_vmem: got %0d required 0", v_m); end
        n_cmp++; if (spike_m !== 1'b0) begin n_err++; $display("FAIL rst_spike: got %0b required 0", spike_m); end
        n_cmp++; if (a_m !== 9'd0 || b_m !== 9'd0) begin n_err++; $display("FAIL rst_mul: got a=%0d b=%0d required 0 0", a_m, b_m); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (rdy_m !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %0b required 1", rdy_m); end
        n_cmp++; if (busy_m !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0b required 0", busy_m); end
        n_cmp++; if (v_s !== 9'd0 || rdy_s !== 1'b1) begin n_err++; $display("FAIL rst_sat: got v=%0d rdy=%0b required 0 1", v_s, rdy_s); end
    endtask

    task automatic test_basic();
        bit ok, fire;
        int ev;
        int va;
        va = mv_m;
        lif_model(mv_m, 100, 256, TH_M, ev, fire);
        start_txn(1'b0, 9'd100, 9'd256, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL basic_accept: got timeout required handshake"); end
        n_cmp++; if (rdy_m !== 1'b0 || busy_m !== 1'b1) begin n_err++; $display("FAIL basic_busy_c1: got rdy=%0b busy=%0b required 0 1", rdy_m, busy_m); end
        n_cmp++; if (a_m !== 9'(va) || b_m !== 9'd256) begin n_err++; $display("FAIL basic_operands: got a=%0d b=%0d required %0d 256", a_m, b_m, va); end
        @(negedge clk);
        n_cmp++; if (v_m !== 9'(va)) begin n_err++; $display("FAIL basic_vmem_c2: got %0d required %0d", v_m, va); end
        @(negedge clk);
        n_cmp++; if (v_m !== 9'(ev) || spike_m !== fire) begin n_err++; $display("FAIL basic_update: got v=%0d spk=%0b required %0d %0b", v_m, spike_m, ev, fire); end
        n_cmp++; if (rdy_m !== 1'b1) begin n_err++; $display("FAIL basic_ready_c3: got %0b required 1", rdy_m); end
        mv_m = ev;
    endtask

    task automatic test_spike_refrac();
        bit ok, fire;
        int ev;
        lif_model(mv_m, 128, 256, TH_M, ev, fire);
        start_txn(1'b0, 9'd128, 9'd256, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL spk_accept: got timeout required handshake"); end
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (spike_m !== fire) begin n_err++; $display("FAIL spk_pulse: got %0b required %0b", spike_m, fire); end
        n_cmp++; if (v_m !== 9'(ev)) begin n_err++; $display("FAIL spk_vmem: got %0d required %0d", v_m, ev); end
        n_cmp++; if (rdy_m !== 1'b0) begin n_err++; $display("FAIL spk_ready_c3: got %0b required 0", rdy_m); end
        for (int k = 4; k <= 7; k++) begin
            @(negedge clk);
            n_cmp++; if (rdy_m !== (k == 7)) begin n_err++; $display("FAIL refrac_ready_c%0d: got %0b required %0b", k, rdy_m, (k == 7)); end
            n_cmp++; if (spike_m !== 1'b0) begin n_err++; $display("FAIL spk_width_c%0d: got %0b required 0", k, spike_m); end
        end
        mv_m = ev;
    endtask

    task automatic test_leak();
        bit ok, fire;
        int ev;
        lif_model(mv_m, 128, 0, TH_M, ev, fire);
        start_txn(1'b0, 9'd128, 9'd0, ok);
        @(negedge clk); @(negedge clk);
        n_cmp++; if (!ok || v_m !== 9'(ev)) begin n_err++; $display("FAIL beta_zero: got %0d required %0d", v_m, ev); end
        mv_m = ev;
        lif_model(mv_m, 0, 128, TH_M, ev, fire);
        start_txn(1'b0, 9'd0, 9'd128, ok);
        @(negedge clk); @(negedge clk);
        n_cmp++; if (!ok || v_m !== 9'(ev) || spike_m !== fire) begin n_err++; $display("FAIL leak_half: got v=%0d spk=%0b required %0d %0b", v_m, spike_m, ev, fire); end
        mv_m = ev;
    endtask

    task automatic test_saturation();
        bit ok, fire;
        int ev;
        logic [8:0] cs [4] = '{9'd300, 9'd300, 9'd300, 9'd0};
        logic [8:0] bs [4] = '{9'd256, 9'd256, 9'd0,   9'd511};
        for (int i = 0; i < 4; i++) begin
            lif_model(mv_s, int'(cs[i]), int'(bs[i]), TH_S, ev, fire);
            start_txn(1'b1, cs[i], bs[i], ok);
            @(negedge clk); @(negedge clk);
            n_cmp++; if (!ok || v_s !== 9'(ev) || spike_s !== fire) begin n_err++; $display("FAIL sat_step%0d: got v=%0d spk=%0b required %0d %0b", i, v_s, spike_s, ev, fire); end
            n_cmp++; if (rdy_s !== 1'b1) begin n_err++; $display("FAIL sat_norefrac%0d: got %0b required 1", i, rdy_s); end
            mv_s = ev;
        end
    endtask

    task automatic test_reset_midop();
        bit ok, fire;
        int ev;
        start_txn(1'b0, 9'd20, 9'd256, ok);
        @(negedge clk);           // now in UPD
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (v_m !== 9'd0 || spike_m !== 1'b0) begin n_err++; $display("FAIL midrst_out: got v=%0d spk=%0b required 0 0", v_m, spike_m); end
        n_cmp++; if (busy_m !== 1'b0 || rdy_m !== 1'b1) begin n_err++; $display("FAIL midrst_state: got busy=%0b rdy=%0b required 0 1", busy_m, rdy_m); end
        @(negedge clk);
        rst_n = 1'b1;
        mv_m = 0;
        mv_s = 0;
        lif_model(mv_m, 50, 200, TH_M, ev, fire);
        start_txn(1'b0, 9'd50, 9'd200, ok);
        @(negedge clk); @(negedge clk);
        n_cmp++; if (!ok || v_m !== 9'(ev)) begin n_err++; $display("FAIL midrst_after: got %0d required %0d", v_m, ev); end
        mv_m = ev;
    endtask

    task automatic test_held_valid();
        int hs[$];
        int exp_hs[$];
        int spikes = 0;
        int exp_spikes = 0;
        int n = 0;
        int t = 0;
        int vn;
        bit fire;
        // Expected acceptance schedule from the model: 3 cycles per step plus refractory after a spike.
        while (t < 35) begin
            exp_hs.push_back(t);
            lif_model(mv_m, 250, 256, TH_M, vn, fire);
            mv_m = vn;
            if (fire && t + 3 < 35) exp_spikes++;
            t += fire ? 3 + RC_M : 3;
        end
        @(negedge clk);
        while (rdy_m !== 1'b1 && n < 30) begin @(negedge clk); n++; end
        cur = 9'd250; beta = 9'd256; valid_m = 1'b1;
        $display("txn dut=main held-valid cur=250 beta=256 window=35");
        for (int i = 0; i < 35; i++) begin
            if (rdy_m === 1'b1 && valid_m) hs.push_back(i);
            if (spike_m === 1'b1) spikes++;
            @(negedge clk);
        end
        valid_m = 1'b0;
        n_cmp++; if (hs.size() != exp_hs.size()) begin n_err++; $display("FAIL held_hs_count: got %0d required %0d", hs.size(), exp_hs.size()); end
        n_cmp++; if (spikes != exp_spikes) begin n_err++; $display("FAIL held_spikes: got %0d required %0d", spikes, exp_spikes); end
        for (int i = 0; i < hs.size() && i < exp_hs.size(); i++) begin
            n_cmp++; if (hs[i] != exp_hs[i]) begin n_err++; $display("FAIL held_hs_cycle%0d: got %0d required %0d", i, hs[i], exp_hs[i]); end
        end
        repeat (8) @(negedge clk);
        n_cmp++; if (v_m !== 9'(mv_m)) begin n_err++; $display("FAIL held_vmem: got %0d required %0d", v_m, mv_m); end
    endtask

    task automatic test_random();
        bit ok, fire, sel;
        int ev, c, b;
        for (int i = 0; i < 40; i++) begin
            sel = 1'($urandom_range(0, 1));
            c = $urandom_range(0, 511);
            b = ($urandom_range(0, 3) == 0) ? 256 : $urandom_range(0, 511);
            if (i % 4 == 0) c = $urandom_range(0, 150);
            lif_model(sel ? mv_s : mv_m, c, b, sel ? TH_S : TH_M, ev, fire);
            start_txn(sel, 9'(c), 9'(b), ok);
            @(negedge clk); @(negedge clk);
            if (sel) begin
                n_cmp++; if (!ok || v_s !== 9'(ev) || spike_s !== fire) begin n_err++; $display("FAIL rand%0d_sat: got v=%0d spk=%0b required %0d %0b", i, v_s, spike_s, ev, fire); end
                mv_s = ev;
            end else begin
                n_cmp++; if (!ok || v_m !== 9'(ev) || spike_m !== fire) begin n_err++; $display("FAIL rand%0d_main: got v=%0d spk=%0b required %0d %0b", i, v_m, spike_m, ev, fire); end
                n_cmp++; if (rdy_m !== !fire) begin n_err++; $display("FAIL rand%0d_ready: got %0b required %0b", i, rdy_m, !fire); end
                mv_m = ev;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_spike_refrac();
        test_leak();
        test_saturation();
        test_reset_midop();
        test_held_valid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion required finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
